// File: rtl/frontend_inst_queue.sv
// Dual-issue instruction queue between fetch and decode: a circular buffer of {pc, inst} entries.
// Define FRONTEND_INST_QUEUE_PERF_EN to build the empty/full performance counters.
module frontend_inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  f_valid_i,
  input  logic [63:0] f_inst_i,
  input  logic [63:0] f_pc_i,
  output logic        f_ready_o,
  output logic [63:0] inst_o,
  output logic [63:0] pc_o,
  output logic [1:0]  inst_valid_o,
  input  logic [1:0]  issue_i,
  input  logic        flush_i,
  output logic [31:0] empty_cnt_o,
  output logic [31:0] full_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - 2);
  localparam logic [CntW-1:0] CntTwo   = CntW'(2);

  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] head_p1, tail_p1;
  logic [1:0]      issue_eff;
  logic [1:0]      pop_n, push_n;
  logic            accept;
  logic [31:0]     wr_inst, wr_pc;

  assign head_p1 = head_q + PtrW'(1);
  assign tail_p1 = tail_q + PtrW'(1);

  // Ready depends only on registered count so fetch never sees a combinational path from issue.
  assign f_ready_o       = (count_q <= ReadyMax);
  assign inst_valid_o[0] = (count_q != '0);
  assign inst_valid_o[1] = (count_q >= CntTwo);

  assign inst_o = {inst_mem[head_p1], inst_mem[head_q]};
  assign pc_o   = {pc_mem[head_p1], pc_mem[head_q]};

  assign accept = f_ready_o && (f_valid_i != 2'b00);

  // In-order pop only: slot 1 alone cannot retire ahead of slot 0.
  assign issue_eff = issue_i & inst_valid_o;

  always_comb begin
    pop_n = 2'd0;
    if (issue_eff[0]) begin
      pop_n = issue_eff[1] ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    push_n = 2'd0;
    if (accept) begin
      push_n = (f_valid_i == 2'b11) ? 2'd2 : 2'd1;
    end
  end

  // Compaction: the first valid slot always lands at the tail.
  always_comb begin
    wr_inst = f_inst_i[31:0];
    wr_pc   = f_pc_i[31:0];
    if (!f_valid_i[0]) begin
      wr_inst = f_inst_i[63:32];
      wr_pc   = f_pc_i[63:32];
    end
  end

  always_comb begin
    head_d  = head_q + PtrW'(pop_n);
    tail_d  = tail_q + PtrW'(push_n);
    count_d = count_q - CntW'(pop_n) + CntW'(push_n);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      inst_mem[tail_q] <= wr_inst;
      pc_mem[tail_q]   <= wr_pc;
      if (f_valid_i == 2'b11) begin
        inst_mem[tail_p1] <= f_inst_i[63:32];
        pc_mem[tail_p1]   <= f_pc_i[63:32];
      end
    end
  end

`ifdef FRONTEND_INST_QUEUE_PERF_EN
  logic [31:0] empty_cnt_q, full_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      empty_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      if ((count_q == '0) && (empty_cnt_q != 32'hFFFF_FFFF)) begin
        empty_cnt_q <= empty_cnt_q + 32'd1;
      end
      if ((f_valid_i != 2'b00) && !f_ready_o && (full_cnt_q != 32'hFFFF_FFFF)) begin
        full_cnt_q <= full_cnt_q + 32'd1;
      end
    end
  end

  assign empty_cnt_o = empty_cnt_q;
  assign full_cnt_o  = full_cnt_q;
`else
  assign empty_cnt_o = 32'd0;
  assign full_cnt_o  = 32'd0;
`endif

endmodule
